prefetch_queue: RTL and testbench



---
 rtl/prefetch_pkg.sv | 17 +
 rtl/prefetch_queue_if.sv | 60 ++++++
 rtl/prefetch_queue_ram.sv | 25 ++
 rtl/prefetch_queue.sv | 133 +++++++++++++
 tb/tb_prefetch_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_pkg.sv
// Shared definitions for the prefetch queue: default widths, fault marker codes and entry layout.
package prefetch_pkg;

    localparam int PREFETCH_DATA_W     = 32;
    localparam int PREFETCH_LEN_W      = 4;
    localparam int PREFETCH_DEPTH_LOG2 = 4;

    // Marker codes travel in the length field of an otherwise all-zero entry.
    localparam logic [PREFETCH_LEN_W-1:0] PREFETCH_GP_FAULT = 4'd15;
    localparam logic [PREFETCH_LEN_W-1:0] PREFETCH_PF_FAULT = 4'd14;

    typedef struct packed {
        logic [PREFETCH_LEN_W-1:0]  len;
        logic [PREFETCH_DATA_W-1:0] data;
    } prefetch_entry_t;

endpackage

// File: rtl/prefetch_queue_if.sv
// Handshake bundle between prefetch engine / fetch-decode (master) and the prefetch queue (slave).
// Optional high-water-mark output is present when PREFETCH_QUEUE_HWM_EN is defined.
interface prefetch_queue_if
    import prefetch_pkg::*;
#(
    parameter int DATA_W     = PREFETCH_DATA_W,
    parameter int LEN_W      = PREFETCH_LEN_W,
    parameter int DEPTH_LOG2 = PREFETCH_DEPTH_LOG2
) ();

    logic                      pr_reset;
    logic                      prefetchfifo_signal_limit_do;
    logic                      prefetchfifo_signal_pf_do;
    logic                      prefetchfifo_write_do;
    logic [LEN_W+DATA_W-1:0]   prefetchfifo_write_data;
    logic [DEPTH_LOG2:0]       prefetchfifo_used;
    logic                      prefetchfifo_fault_held;
    logic                      prefetchfifo_overflow;
    logic                      prefetchfifo_accept_do;
    logic [LEN_W+2*DATA_W-1:0] prefetchfifo_accept_data;
    logic                      prefetchfifo_accept_empty;
`ifdef PREFETCH_QUEUE_HWM_EN
    logic [DEPTH_LOG2:0]       prefetchfifo_hwm;
`endif

    modport master (
        output pr_reset,
        output prefetchfifo_signal_limit_do,
        output prefetchfifo_signal_pf_do,
        output prefetchfifo_write_do,
        output prefetchfifo_write_data,
        output prefetchfifo_accept_do,
        input  prefetchfifo_used,
        input  prefetchfifo_fault_held,
        input  prefetchfifo_overflow,
        input  prefetchfifo_accept_data,
        input  prefetchfifo_accept_empty
`ifdef PREFETCH_QUEUE_HWM_EN
        , input prefetchfifo_hwm
`endif
    );

    modport slave (
        input  pr_reset,
        input  prefetchfifo_signal_limit_do,
        input  prefetchfifo_signal_pf_do,
        input  prefetchfifo_write_do,
        input  prefetchfifo_write_data,
        input  prefetchfifo_accept_do,
        output prefetchfifo_used,
        output prefetchfifo_fault_held,
        output prefetchfifo_overflow,
        output prefetchfifo_accept_data,
        output prefetchfifo_accept_empty
`ifdef PREFETCH_QUEUE_HWM_EN
        , output prefetchfifo_hwm
`endif
    );

endinterface

// File: rtl/prefetch_queue_ram.sv
// Entry storage for the prefetch queue: clocked write, asynchronous read, contents never reset.
module prefetch_queue_ram #(
    parameter int WIDTH  = 36,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [2**ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/prefetch_queue.sv
// Show-ahead prefetch queue with GP/PF fault markers, sticky fault blocking and overflow flag.
// Define PREFETCH_QUEUE_HWM_EN to add the prefetchfifo_hwm high-water-mark output.
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int DATA_W     = PREFETCH_DATA_W,
    parameter int LEN_W      = PREFETCH_LEN_W,
    parameter int DEPTH_LOG2 = PREFETCH_DEPTH_LOG2
) (
    input  logic           clk,
    input  logic           rst_n,
    prefetch_queue_if.slave bus
);

    localparam int ENT_W = LEN_W + DATA_W;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1'b1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  fault_held_r;
    logic                  overflow_r;

    logic                  push_req_s;
    logic                  fault_req_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [ENT_W-1:0]      push_entry_s;
    logic [ENT_W-1:0]      head_s;

    // Source selection and push/pop qualification
    always_comb begin
        push_req_s   = bus.prefetchfifo_signal_limit_do | bus.prefetchfifo_signal_pf_do |
                       bus.prefetchfifo_write_do;
        fault_req_s  = bus.prefetchfifo_signal_limit_do | bus.prefetchfifo_signal_pf_do;
        push_entry_s = bus.prefetchfifo_write_data;
        if (bus.prefetchfifo_signal_limit_do) begin
            push_entry_s = {LEN_W'(PREFETCH_GP_FAULT), {DATA_W{1'b0}}};
        end else if (bus.prefetchfifo_signal_pf_do) begin
            push_entry_s = {LEN_W'(PREFETCH_PF_FAULT), {DATA_W{1'b0}}};
        end else begin
            push_entry_s = bus.prefetchfifo_write_data;
        end
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == FULL_CNT);
        pop_s   = bus.prefetchfifo_accept_do & ~empty_s;
        // A pop in the same cycle frees the slot, so a full queue may still accept.
        push_s  = push_req_s & ~fault_held_r & (~full_s | pop_s);
        drop_s  = push_req_s & ~fault_held_r & full_s & ~pop_s;
    end

    // Pointer, occupancy, sticky fault and overflow state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r     <= {DEPTH_LOG2{1'b0}};
            count_r      <= CNT_ZERO;
            fault_held_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (bus.pr_reset) begin
            wr_ptr_r     <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r     <= {DEPTH_LOG2{1'b0}};
            count_r      <= CNT_ZERO;
            fault_held_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
            if (push_s && fault_req_s) begin
                fault_held_r <= 1'b1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    prefetch_queue_ram #(
        .WIDTH  (ENT_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (push_entry_s),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    assign bus.prefetchfifo_used         = count_r;
    assign bus.prefetchfifo_fault_held   = fault_held_r;
    assign bus.prefetchfifo_overflow     = overflow_r;
    assign bus.prefetchfifo_accept_empty = empty_s;
    assign bus.prefetchfifo_accept_data  = {head_s[ENT_W-1 -: LEN_W], {DATA_W{1'b0}},
                                            head_s[DATA_W-1:0]};

`ifdef PREFETCH_QUEUE_HWM_EN
    logic [DEPTH_LOG2:0] hwm_r;

    // High-water mark follows the registered count, so it lags a count change by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_r <= CNT_ZERO;
        end else if (bus.pr_reset) begin
            hwm_r <= CNT_ZERO;
        end else if (count_r > hwm_r) begin
            hwm_r <= count_r;
        end else begin
            hwm_r <= hwm_r;
        end
    end

    assign bus.prefetchfifo_hwm = hwm_r;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_prefetch_queue;
    import prefetch_pkg::*;

    localparam int DW    = 32;
    localparam int LW    = 4;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int EW    = LW + DW;
    localparam int AW    = LW + 2 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prefetch_queue_if #(.DATA_W(DW), .LEN_W(LW), .DEPTH_LOG2(DL)) pq ();

    prefetch_queue #(.DATA_W(DW), .LEN_W(LW), .DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pq)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] mq[$];
    logic          m_fh;
    logic          m_ov;
    int            m_hwm;

    typedef struct {
        logic          lim, pf, wr;
        logic [EW-1:0] data;
        logic          acc, fl;
        int            used;
        logic          empty, fh, ov;
        logic [AW-1:0] head;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] shown(input logic [EW-1:0] e);
        logic [AW-1:0] r;
        r = {e[EW-1:DW], {DW{1'b0}}, e[DW-1:0]};
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fh  = 1'b0;
        m_ov  = 1'b0;
        m_hwm = 0;
    endtask

    // Queue semantics: flush wins; pop first (if non-empty); then at most one push.
    task automatic model_step(input logic lim, pf, wr, input logic [EW-1:0] d, input logic acc, fl);
        int   sz;
        logic popped;
        sz = mq.size();
        if (fl) begin
            model_reset();
        end else begin
            if (sz > m_hwm) m_hwm = sz;
            popped = acc && (sz > 0);
            if (popped) void'(mq.pop_front());
            if ((lim || pf || wr) && !m_fh) begin
                if (sz < DEPTH || popped) begin
                    if (lim)     mq.push_back({PREFETCH_GP_FAULT, {DW{1'b0}}});
                    else if (pf) mq.push_back({PREFETCH_PF_FAULT, {DW{1'b0}}});
                    else         mq.push_back(d);
                    if (lim || pf) m_fh = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic lim, pf, wr, input logic [EW-1:0] d, input logic acc, fl);
        pq.prefetchfifo_signal_limit_do = lim;
        pq.prefetchfifo_signal_pf_do    = pf;
        pq.prefetchfifo_write_do        = wr;
        pq.prefetchfifo_write_data      = d;
        pq.prefetchfifo_accept_do       = acc;
        pq.pr_reset                     = fl;
        model_step(lim, pf, wr, d, acc, fl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".used"},  AW'(pq.prefetchfifo_used), AW'(mq.size()));
        check({tag, ".empty"}, AW'(pq.prefetchfifo_accept_empty), AW'(mq.size() == 0));
        check({tag, ".fault"}, AW'(pq.prefetchfifo_fault_held), AW'(m_fh));
        check({tag, ".ovf"},   AW'(pq.prefetchfifo_overflow), AW'(m_ov));
        if (mq.size() > 0) check({tag, ".head"}, pq.prefetchfifo_accept_data, shown(mq[0]));
`ifdef PREFETCH_QUEUE_HWM_EN
        check({tag, ".hwm"},   AW'(pq.prefetchfifo_hwm), AW'(m_hwm));
`endif
    endtask

    initial begin
        logic [EW-1:0] d1, d2, da, z;
        logic [AW-1:0] h1, h2, hg, hp, h0;
        d1 = 36'h4_11223344; d2 = 36'h4_55667788; da = 36'h4_AAAAAAAA; z = 36'h0;
        h1 = 68'h4_00000000_11223344; h2 = 68'h4_00000000_55667788;
        hg = 68'hF_00000000_00000000; hp = 68'hE_00000000_00000000; h0 = 68'h0;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, d1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, h1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, d2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, h1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, z,  1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, h2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, z,  1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, z,  1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, da, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, hg};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, da, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, hg};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, da, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, hg};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, da, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, hg};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, z,  1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, hg};
        tbl[10] = '{1'b0, 1'b0, 1'b0, z,  1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, h0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, z,  1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, hp};
        tbl[12] = '{1'b0, 1'b0, 1'b1, d1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, h0};

        pq.pr_reset = 1'b0; pq.prefetchfifo_signal_limit_do = 1'b0; pq.prefetchfifo_signal_pf_do = 1'b0;
        pq.prefetchfifo_write_do = 1'b0; pq.prefetchfifo_write_data = '0; pq.prefetchfifo_accept_do = 1'b0;
        model_reset();

        // Reset state while rst_n is held low
        @(negedge clk);
        check("rst.used",  AW'(pq.prefetchfifo_used), AW'(0));
        check("rst.empty", AW'(pq.prefetchfifo_accept_empty), AW'(1));
        check("rst.fault", AW'(pq.prefetchfifo_fault_held), AW'(0));
        check("rst.ovf",   AW'(pq.prefetchfifo_overflow), AW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].lim, tbl[i].pf, tbl[i].wr, tbl[i].data, tbl[i].acc, tbl[i].fl);
            check($sformatf("tbl%0d.used", i),  AW'(pq.prefetchfifo_used), AW'(tbl[i].used));
            check($sformatf("tbl%0d.empty", i), AW'(pq.prefetchfifo_accept_empty), AW'(tbl[i].empty));
            check($sformatf("tbl%0d.fault", i), AW'(pq.prefetchfifo_fault_held), AW'(tbl[i].fh));
            check($sformatf("tbl%0d.ovf", i),   AW'(pq.prefetchfifo_overflow), AW'(tbl[i].ov));
            if (!tbl[i].empty) check($sformatf("tbl%0d.head", i), pq.prefetchfifo_accept_data, tbl[i].head);
        end

        // Fill to full, overflow, push+pop at full, drain to entry 17
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, {4'h1, 32'(i)}, 1'b0, 1'b0);
            check_model($sformatf("fill%0d", i));
        end
        check("full.used", AW'(pq.prefetchfifo_used), AW'(16));
        drive(1'b0, 1'b0, 1'b1, {4'h1, 32'd100}, 1'b0, 1'b0);
        check("ovf.used", AW'(pq.prefetchfifo_used), AW'(16));
        check("ovf.flag", AW'(pq.prefetchfifo_overflow), AW'(1));
        drive(1'b0, 1'b0, 1'b1, {4'h1, 32'd16}, 1'b1, 1'b0);
        check("fullpp.used", AW'(pq.prefetchfifo_used), AW'(16));
        check("fullpp.head", pq.prefetchfifo_accept_data, 68'h1_00000000_00000001);
`ifdef PREFETCH_QUEUE_HWM_EN
        check("hwm.full", AW'(pq.prefetchfifo_hwm), AW'(16));
`endif
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 1'b0, z, 1'b1, 1'b0);
            check_model($sformatf("drain%0d", i));
        end
        check("e17.head", pq.prefetchfifo_accept_data, 68'h1_00000000_00000010);
        check("e17.used", AW'(pq.prefetchfifo_used), AW'(1));

        // Flush with push and pop in the same cycle at used = 5
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, {4'h2, 32'(i)}, 1'b0, 1'b0);
        check("pre.used", AW'(pq.prefetchfifo_used), AW'(5));
        drive(1'b0, 1'b0, 1'b1, d2, 1'b1, 1'b1);
        check("fl.used",  AW'(pq.prefetchfifo_used), AW'(0));
        check("fl.empty", AW'(pq.prefetchfifo_accept_empty), AW'(1));
        check("fl.fault", AW'(pq.prefetchfifo_fault_held), AW'(0));
        check("fl.ovf",   AW'(pq.prefetchfifo_overflow), AW'(0));
`ifdef PREFETCH_QUEUE_HWM_EN
        check("fl.hwm",   AW'(pq.prefetchfifo_hwm), AW'(0));
`endif

        // Shallow interleaved traffic wrapping the pointers
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'b0, (mq.size() < 3) ? 1'($urandom % 2) : 1'b0,
                  {4'($urandom), 32'($urandom)}, 1'($urandom % 2), 1'b0);
            check_model($sformatf("wrap%0d", i));
        end

        // Unconstrained random traffic including faults, flushes and full
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 30) == 0, ($urandom % 30) == 0, ($urandom % 4) != 0,
                  {4'($urandom), 32'($urandom)}, ($urandom % 3) == 0, ($urandom % 50) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset between clock edges
        drive(1'b0, 1'b0, 1'b0, z, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, {4'h3, 32'(i)}, 1'b0, 1'b0);
        pq.prefetchfifo_write_do = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.used",  AW'(pq.prefetchfifo_used), AW'(0));
        check("arst.empty", AW'(pq.prefetchfifo_accept_empty), AW'(1));
        check("arst.fault", AW'(pq.prefetchfifo_fault_held), AW'(0));
        check("arst.ovf",   AW'(pq.prefetchfifo_overflow), AW'(0));
`ifdef PREFETCH_QUEUE_HWM_EN
        check("arst.hwm",   AW'(pq.prefetchfifo_hwm), AW'(0));
`endif
        model_reset();
        @(negedge clk);
        pq.prefetchfifo_write_do = 1'b0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, d1, 1'b0, 1'b0);
        check_model("post_arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
